// File: rtl/mdr_execution_unit.sv
// mdr_execution_unit: iterative unsigned multiply / divide / square-root engine.
// Accepts a level request (flagStart), captures the operands, runs one iteration
// per clock and holds Ready until the request is withdrawn.
//
// Optional feature macro: MDR_SQRT_EN. When it is defined, Op=10 computes the
// square root. When it is undefined, no sqrt datapath is built and Op=10 is
// rejected as an illegal op.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   flagStart  level request, held until Ready
//   Op         00 mul, 01 div, 10 sqrt, 11 illegal
//   DataX      multiplicand / dividend / radicand
//   DataY      multiplier / divisor
//   Result     mul: product; div: {rem, quot}; sqrt: {rem, root}
//   Ready      result valid / request acknowledge
//   Busy       iterating
//   Error      divide by zero or unsupported op (valid with Ready)
module mdr_execution_unit #(
  parameter int unsigned WORD_LENGTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flagStart,
  input  logic [1:0]                 Op,
  input  logic [WORD_LENGTH-1:0]     DataX,
  input  logic [WORD_LENGTH-1:0]     DataY,
  output logic [2*WORD_LENGTH-1:0]   Result,
  output logic                       Ready,
  output logic                       Busy,
  output logic                       Error
);

  localparam int unsigned W  = WORD_LENGTH;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic [2*W-1:0]  a_q;     // shifted multiplicand
  logic [2*W-1:0]  acc_q;   // product accumulator
  logic [W-1:0]    b_q;     // multiplier / divisor / radicand shifter
  logic [W-1:0]    q_q;     // dividend-quotient shifter / root
  logic [W:0]      rem_q;   // partial remainder

  logic op_illegal_c, div_zero_c;
  logic load_c, iter_c, last_c;

  // Request classification at capture time
  always_comb begin
`ifdef MDR_SQRT_EN
    op_illegal_c = (Op == 2'b11);
`else
    op_illegal_c = Op[1];
`endif
    div_zero_c = (Op == OP_DIV) && (DataY == '0);
  end

  // State register; Ready/Busy registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      Ready <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      Ready <= (state_nxt == S_DONE);
      Busy  <= (state_nxt == S_RUN);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (flagStart) state_nxt = (op_illegal_c || div_zero_c) ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == CW'(1)) state_nxt = S_DONE;
      S_DONE: if (!flagStart) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    load_c = (state == S_IDLE) && flagStart;
    iter_c = (state == S_RUN);
    last_c = iter_c && (cnt_q == CW'(1));
  end

  // Shift-add multiply step
  logic [2*W-1:0] mul_acc_nxt;
  // Restoring divide step; the extra top bit of the trial holds the borrow
  logic [W+1:0]   div_shift, div_trial;
  logic [W:0]     div_rem_nxt;
  logic [W-1:0]   div_q_nxt;
  logic           div_neg;

  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    div_shift   = {rem_q, q_q[W-1]};
    div_trial   = div_shift - {2'b00, b_q};
    div_neg     = div_trial[W+1];
    div_rem_nxt = div_neg ? div_shift[W:0] : div_trial[W:0];
    div_q_nxt   = {q_q[W-2:0], ~div_neg};
  end

`ifdef MDR_SQRT_EN
  // Digit-by-digit root: bring in two radicand bits, try subtracting 4*root+1
  logic [W+1:0] sq_shift, sq_trial;
  logic [W:0]   sq_rem_nxt;
  logic [W-1:0] sq_root_nxt;
  logic         sq_neg;

  always_comb begin
    sq_shift    = {rem_q[W-1:0], b_q[W-1:W-2]};
    sq_trial    = sq_shift - {q_q, 2'b01};
    sq_neg      = sq_trial[W+1];
    sq_rem_nxt  = sq_neg ? sq_shift[W:0] : sq_trial[W:0];
    sq_root_nxt = {q_q[W-2:0], ~sq_neg};
  end
`endif

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      q_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      Result <= '0;
      Error  <= 1'b0;
    end else if (load_c) begin
      op_q  <= Op;
      Error <= 1'b0;
      a_q   <= (2*W)'(DataX);
      b_q   <= (Op == OP_SQRT) ? DataX : DataY;
      q_q   <= (Op == OP_DIV) ? DataX : '0;
      acc_q <= '0;
      rem_q <= '0;
      if (div_zero_c) begin
        Error  <= 1'b1;
        Result <= {DataX, {W{1'b1}}};
        cnt_q  <= '0;
      end else if (op_illegal_c) begin
        Error  <= 1'b1;
        Result <= '0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= (Op == OP_SQRT) ? CW'(W / 2) : CW'(W);
      end
    end else if (iter_c) begin
      cnt_q <= cnt_q - CW'(1);
      case (op_q)
        OP_MUL: begin
          acc_q <= mul_acc_nxt;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          if (last_c) Result <= mul_acc_nxt;
        end
        OP_DIV: begin
          rem_q <= div_rem_nxt;
          q_q   <= div_q_nxt;
          if (last_c) Result <= {div_rem_nxt[W-1:0], div_q_nxt};
        end
`ifdef MDR_SQRT_EN
        OP_SQRT: begin
          rem_q <= sq_rem_nxt;
          q_q   <= sq_root_nxt;
          b_q   <= {b_q[W-3:0], 2'b00};
          if (last_c) Result <= {sq_rem_nxt[W-1:0], sq_root_nxt};
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_execution_unit.sv
// Scoreboard bench for mdr_execution_unit (WORD_LENGTH=16). Stimulus pushes the
// expected response per request; a negedge monitor checks each Ready window.
module tb_mdr_execution_unit;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           flagStart;
  logic [1:0]     Op;
  logic [W-1:0]   DataX, DataY;
  logic [2*W-1:0] Result;
  logic           Ready, Busy, Error;

  mdr_execution_unit #(.WORD_LENGTH(W)) dut (
    .clk(clk), .reset(reset), .flagStart(flagStart), .Op(Op),
    .DataX(DataX), .DataY(DataY), .Result(Result),
    .Ready(Ready), .Busy(Busy), .Error(Error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             lat;
    int             busy;
    int             width;
    int             start;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: measures latency, busy cycles and Ready width per response
  exp_t cur;
  bit   has_cur  = 0;
  bit   in_ready = 0;
  int   busy_cnt = 0;
  int   width_cnt = 0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      busy_cnt = 0;
      in_ready = 0;
    end else begin
      if (Busy === 1'b1) busy_cnt++;
      if (Ready === 1'b1 && !in_ready) begin
        in_ready  = 1;
        width_cnt = 1;
        if (sb.size() == 0) begin
          has_cur = 0;
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          has_cur = 1;
          chk("result",  Result, cur.res);
          chk("error",   32'(Error), 32'(cur.err));
          chk("latency", 32'(cyc - cur.start), 32'(cur.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(cur.busy));
        end
        busy_cnt = 0;
      end else if (Ready === 1'b1) begin
        width_cnt++;
      end else if (in_ready) begin
        in_ready = 0;
        if (has_cur) chk("ready_width", 32'(width_cnt), 32'(cur.width));
        has_cur = 0;
      end
    end
  end

  // Issue one request; hold flagStart 'hold' cycles past Ready, or drop it
  // 'drop_after' cycles into RUN when non-zero.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] res, input logic err, input int lat,
                        input int busy, input int hold, input int drop_after);
    exp_t e;
    int   t;
    @(negedge clk);
    Op = op; DataX = x; DataY = y; flagStart = 1'b1;
    e.res = res; e.err = err; e.lat = lat; e.busy = busy;
    e.width = (drop_after > 0) ? 1 : hold + 1;
    e.start = cyc;
    sb.push_back(e);
    @(negedge clk);
    // Operands change after capture; must have no effect
    DataX = ~x; DataY = ~y; Op = ~op;
    if (drop_after > 0) begin
      repeat (drop_after - 1) @(negedge clk);
      flagStart = 1'b0;
    end
    t = 0;
    while (Ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (Ready !== 1'b1) begin
      chk("ready_timeout", 32'(Ready), 32'd1);
    end else if (drop_after == 0) begin
      repeat (hold) @(negedge clk);
      flagStart = 1'b0;
    end
    flagStart = 1'b0;
    t = 0;
    while (Ready === 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("ready_release", 32'(Ready), 32'd0);
    chk("result_hold_idle", Result, res);
  endtask

  initial begin
    reset = 1'b1; flagStart = 1'b0; Op = 2'b00; DataX = '0; DataY = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", Result, 32'd0);
    chk("rst_ready",  32'(Ready), 32'd0);
    chk("rst_busy",   32'(Busy),  32'd0);
    chk("rst_error",  32'(Error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // op, X, Y, result, err, latency, busy, hold, drop_after
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 17, 16, 2, 0);
    run_op(2'b00, 16'h1234, 16'h0000, 32'h00000000, 1'b0, 17, 16, 0, 0);
    run_op(2'b01, 16'd100,  16'd7,    32'h0002000E, 1'b0, 17, 16, 3, 0);
    run_op(2'b01, 16'hFFFF, 16'h0001, 32'h0000FFFF, 1'b0, 17, 16, 0, 0);
    run_op(2'b01, 16'd5,    16'd9,    32'h00050000, 1'b0, 17, 16, 0, 0);
    run_op(2'b01, 16'h1234, 16'h0000, 32'h1234FFFF, 1'b1, 1,  0,  1, 0);
`ifdef MDR_SQRT_EN
    run_op(2'b10, 16'd145,  16'h5555, 32'h0001000C, 1'b0, 9,  8,  0, 0);
    run_op(2'b10, 16'hFFFF, 16'h0000, 32'h01FE00FF, 1'b0, 9,  8,  1, 0);
`else
    run_op(2'b10, 16'd145,  16'h5555, 32'h00000000, 1'b1, 1,  0,  0, 0);
`endif
    run_op(2'b11, 16'd145,  16'h0003, 32'h00000000, 1'b1, 1,  0,  0, 0);

    // Reset on the 5th RUN cycle of a multiply abandons it
    @(negedge clk);
    Op = 2'b00; DataX = 16'hFFFF; DataY = 16'hFFFF; flagStart = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1; flagStart = 1'b0;
    @(negedge clk);
    chk("midrun_rst_result", Result, 32'd0);
    chk("midrun_rst_ready",  32'(Ready), 32'd0);
    chk("midrun_rst_busy",   32'(Busy),  32'd0);
    chk("midrun_rst_error",  32'(Error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(Busy), 32'd0);

    run_op(2'b00, 16'd3, 16'd5, 32'd15, 1'b0, 17, 16, 0, 0);
    // flagStart dropped mid-RUN: completes, Ready is a single-cycle pulse
    run_op(2'b01, 16'd100, 16'd7, 32'h0002000E, 1'b0, 17, 16, 0, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdr_execution_unit.md
# mdr_execution_unit

Arithmetic engine that consumes the operand-load controller's `flagStart` handshake and returns `Ready` when done. It operates on the two loaded channel values (X, Y) and computes unsigned multiply, divide or square root, one iteration per clock. It sits between the channel operand registers and the result/display path of the MDR datapath.

## Interface
- `WORD_LENGTH`, default 16: operand width; must be even and ≥ 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flagStart`  in  1  level request from the operand-load controller; held high until `Ready` is seen.
- `Op`  in  2  operation: 00 multiply, 01 divide, 10 square root, 11 illegal.
- `DataX`  in  WORD_LENGTH  channel 1 operand (multiplicand / dividend / radicand).
- `DataY`  in  WORD_LENGTH  channel 2 operand (multiplier / divisor; ignored for sqrt).
- `Result`  out  2*WORD_LENGTH  multiply: full product; divide: {remainder, quotient}; sqrt: {remainder, root zero-extended}.
- `Ready`  out  1  result valid / request acknowledge.
- `Busy`  out  1  high while iterating.
- `Error`  out  1  divide by zero or unsupported op; valid while `Ready`=1.

## Operation
- All arithmetic is unsigned. No internal state is shared between operations.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `Ready`=0, `Busy`=0. When `flagStart`=1, capture `Op`, `DataX`, `DataY` into internal registers and clear `Error`.
    - Divide with `DataY`=0: go to DONE with `Error`=1, quotient all ones, remainder = `DataX`.
    - `Op`=11, or `Op`=10 without the sqrt feature: go to DONE with `Error`=1 and `Result`=0.
    - Otherwise load the iteration counter (WORD_LENGTH for mul/div, WORD_LENGTH/2 for sqrt) and go to RUN.
  - RUN: `Busy`=1. Perform one iteration per cycle and decrement the counter. On the final iteration, write `Result` and go to DONE.
    - Multiply: shift-add, LSB of multiplier first; product accumulator is 2*WORD_LENGTH wide.
    - Divide: restoring; the partial remainder is WORD_LENGTH+1 bits to hold the sign of the trial subtraction.
    - Sqrt: digit-by-digit, two radicand bits per iteration.
  - DONE: `Ready`=1. Stay while `flagStart`=1. Go to IDLE on the first cycle `flagStart`=0.
- `flagStart` changes during RUN are ignored; the operation always completes.
- If `flagStart` is already low on entry to DONE, `Ready` is a one-cycle pulse.
- `Result` and `Error` hold their values through IDLE until the next operation writes them.
- Operand inputs are sampled only at the IDLE capture edge; later changes have no effect.
- Reset at any time, including mid-RUN: state goes to IDLE and the in-flight operation is abandoned.

## Timing
- Reset values: `Result`=0, `Ready`=0, `Busy`=0, `Error`=0, state IDLE, counter 0.
- Call the capture edge E (IDLE with `flagStart`=1).
- Multiply/divide: `Busy` is high in the WORD_LENGTH cycles after E; `Ready` is first high WORD_LENGTH+1 cycles after E (17 for WORD_LENGTH=16).
- Sqrt: `Ready` is first high WORD_LENGTH/2+1 cycles after E.
- Error cases: `Ready` is high in the cycle after E; `Busy` never asserts.
- After `flagStart` falls while in DONE, `Ready` drops on the next edge.
- Minimum spacing between operations: one IDLE cycle.
- Outputs are registered or decoded from state only (Moore); there are no combinational paths from inputs to outputs.

## Configuration
- `MDR_SQRT_EN` defined: `Op`=10 performs the square root as described above.
- `MDR_SQRT_EN` undefined: no sqrt hardware is synthesized; `Op`=10 is treated as illegal (`Error`=1, `Result`=0, `Ready` in the cycle after E).

## Test plan
- Reset, then multiply with WORD_LENGTH=16: X=0xFFFF, Y=0xFFFF, `Op`=00, `flagStart` held → `Result`=0xFFFE0001, `Ready` 17 cycles after E, `Error`=0, `Busy` high for exactly 16 cycles.
- Divide: X=100, Y=7, `Op`=01 → `Result`=0x0002000E (rem 2, quot 14); `Ready` held until `flagStart` drops, then IDLE on the next edge.
- Divide by zero: X=0x1234, Y=0 → `Ready` in the cycle after E, `Error`=1, `Result`=0x1234FFFF, `Busy` never asserts.
- Sqrt with `MDR_SQRT_EN` defined: X=145, `Op`=10 → root 12, remainder 1, `Result`=0x0001000C, `Ready` 9 cycles after E.
- Sqrt without `MDR_SQRT_EN`: X=145, `Op`=10 → `Error`=1, `Result`=0. Same check for `Op`=11.
- Assert `reset` on the 5th RUN cycle of a multiply → all outputs return to 0 and state is IDLE. A fresh 3×5 request then yields `Result`=15. Separately, drop `flagStart` mid-RUN → operation completes and `Ready` is a single-cycle pulse.
